// File: rtl/arm_pipe_pkg.sv
// Shared pipeline definitions for the IF/ID fetch queue.
// Holds the stored entry type and the default queue depth.
package arm_pipe_pkg;

   // Default number of buffered fetch entries.
   localparam int IF_ID_DEPTH = 4;

   // Storage width of the PC and instruction fields. This is the widest supported WIDTH.
   // Narrower WIDTH values are zero-extended into these fields.
   localparam int IF_ID_WIDTH = 32;

   // One buffered fetch beat.
   typedef struct packed {
      logic [IF_ID_WIDTH-1:0] pc;
      logic [IF_ID_WIDTH-1:0] instruction;
   } fetch_entry_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue: DEPTH x fetch_entry_t.
// One synchronous write port and one asynchronous read port.
// Contents are never reset, so a reset costs no write cycles.
module if_id_queue_mem
   import arm_pipe_pkg::*;
#(
   parameter int DEPTH = IF_ID_DEPTH,
   parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [PW-1:0] i_waddr,
   input  fetch_entry_t  i_wdata,
   input  logic [PW-1:0] i_raddr,
   output fetch_entry_t  o_rdata
);

   fetch_entry_t r_mem [DEPTH];

   // Write the pushed entry at the write pointer on the clock edge.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID fetch queue: buffers fetched {pc, instruction} beats between
// the fetch and decode stages, with flush for taken branches.
// Optional feature macro: IF_ID_QUEUE_BYPASS_EN. When defined, an empty queue
// forwards an input beat straight to out_* in the same cycle if decode
// is ready; without it there is no combinational in_* -> out_* path.
// Handshake: a beat moves on an interface only in a cycle where its valid and
// ready are both high at the rising edge. flush suppresses both sides.
// WIDTH must not exceed arm_pipe_pkg::IF_ID_WIDTH.
module if_id_queue
   import arm_pipe_pkg::*;
#(
   parameter int DEPTH = IF_ID_DEPTH,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_pc,
   input  logic [WIDTH-1:0]         in_instruction,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_pc,
   output logic [WIDTH-1:0]         out_instruction,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_push;
   logic          w_pop;
   logic          w_bypass;
   logic          w_nonempty;
   fetch_entry_t  w_in_entry;
   fetch_entry_t  w_head;

   assign w_in_entry.pc          = IF_ID_WIDTH'(in_pc);
   assign w_in_entry.instruction = IF_ID_WIDTH'(in_instruction);

   assign w_nonempty = (r_count != '0);

`ifdef IF_ID_QUEUE_BYPASS_EN
   assign w_bypass = !w_nonempty && in_valid && out_ready && !flush;
`else
   assign w_bypass = 1'b0;
`endif

   // Full is judged on the registered count only, so a pop in the same
   // cycle does not open a slot; this keeps in_ready free of out_ready.
   assign in_ready  = (r_count < CW'(DEPTH));
   assign out_valid = (w_nonempty || w_bypass) && !flush;
   assign count     = r_count;

   // A bypassed beat is consumed directly and never written.
   assign w_push = in_valid && in_ready && !flush && !w_bypass;
   assign w_pop  = w_nonempty && out_ready && !flush;

   if_id_queue_mem #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_in_entry),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_head)
   );

   // Select the beat shown to decode: the stored head, or the input when bypassing.
   always_comb begin
      out_pc          = w_head.pc[WIDTH-1:0];
      out_instruction = w_head.instruction[WIDTH-1:0];
      if (w_bypass) begin
         out_pc          = in_pc;
         out_instruction = in_instruction;
      end
   end

   // Pointer and occupancy control; reset beats flush, flush beats push/pop.
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed and random stimulus for if_id_queue with a reference queue of
// expected {pc, instruction} beats. Bypass expectations follow
// IF_ID_QUEUE_BYPASS_EN when it is defined for the build.
module tb_if_id_queue;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_pc;
   logic [WIDTH-1:0] in_instruction;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_pc;
   logic [WIDTH-1:0] out_instruction;
   logic             out_ready;
   logic [CW-1:0]    count;

   if_id_queue #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_pc           (in_pc),
      .in_instruction  (in_instruction),
      .in_ready        (in_ready),
      .out_valid       (out_valid),
      .out_pc          (out_pc),
      .out_instruction (out_instruction),
      .out_ready       (out_ready),
      .count           (count)
   );

   // ---------------- scoreboard ----------------
   logic [2*WIDTH-1:0] exp_q[$];
   int n_checks = 0;
   int n_err    = 0;

   function automatic logic [WIDTH-1:0] instr_of(input logic [WIDTH-1:0] pc);
      return {pc[15:0], ~pc[15:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic offer(input logic v, input logic [WIDTH-1:0] pc);
      in_valid       = v;
      in_pc          = pc;
      in_instruction = instr_of(pc);
   endtask

   // One clock: compare outputs against the reference at the falling edge,
   // update the reference for the coming rising edge, then advance.
   task automatic step();
      int                 sz;
      logic               byp;
      logic               exp_ov;
      logic [2*WIDTH-1:0] head;
      @(negedge clk);
      if (!rst) begin
         exp_q.delete();
      end else begin
         sz  = exp_q.size();
         byp = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
         byp = (sz == 0) && in_valid && out_ready && !flush;
`endif
         exp_ov = ((sz != 0) || byp) && !flush;
         check("count", 64'(count), 64'(sz));
         check("in_ready", 64'(in_ready), 64'(sz < DEPTH));
         check("out_valid", 64'(out_valid), 64'(exp_ov));
         if (exp_ov) begin
            head = byp ? {in_pc, in_instruction} : exp_q[0];
            check("out_pc", 64'(out_pc), 64'(head[2*WIDTH-1:WIDTH]));
            check("out_instruction", 64'(out_instruction), 64'(head[WIDTH-1:0]));
         end
         if (flush) begin
            exp_q.delete();
         end else begin
            if (exp_ov && out_ready && !byp) void'(exp_q.pop_front());
            if (in_valid && !byp && (sz < DEPTH)) exp_q.push_back({in_pc, instr_of(in_pc)});
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      offer(1'b0, '0);

      // Reset held for two cycles, then released.
      step();
      step();
      rst = 1'b1;
      #1;
      check("reset_count", 64'(count), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);

      // Fill to full with decode stalled; a fifth offer must be refused.
      offer(1'b1, 32'h4);  step();
      offer(1'b1, 32'h8);  step();
      offer(1'b1, 32'hC);  step();
      offer(1'b1, 32'h10); step();
      offer(1'b1, 32'h14);
      #1;
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      step();
      // Full with a pop in the same cycle: still not ready, 0x14 not taken.
      out_ready = 1'b1;
      #1;
      check("full_pop_in_ready", 64'(in_ready), 64'd0);
      step();
      offer(1'b0, '0);
      step();
      step();
      step();
      step();

      // Continuous streaming across pointer wrap.
      for (int i = 0; i < 10; i++) begin
         offer(1'b1, 32'h200 + 32'(i * 4));
         step();
      end
      offer(1'b0, '0);
      step();
      step();

      // Flush with three buffered entries and an incoming beat.
      out_ready = 1'b0;
      offer(1'b1, 32'h300); step();
      offer(1'b1, 32'h304); step();
      offer(1'b1, 32'h308); step();
      flush = 1'b1;
      offer(1'b1, 32'h20);
      step();
      flush = 1'b0;
      offer(1'b0, '0);
      #1;
      check("flush_count", 64'(count), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      offer(1'b1, 32'h100);
      step();
      offer(1'b0, '0);
      step();
      step();

      // Reset asserted mid-stream together with push and flush.
      out_ready = 1'b0;
      offer(1'b1, 32'h400); step();
      offer(1'b1, 32'h404); step();
      rst   = 1'b0;
      flush = 1'b1;
      offer(1'b1, 32'h408);
      step();
      rst   = 1'b1;
      flush = 1'b0;
      offer(1'b0, '0);
      out_ready = 1'b1;
      #1;
      check("midreset_count", 64'(count), 64'd0);
      step();
      step();

      // Bypass case: empty queue, input and output both ready.
      offer(1'b1, 32'h40);
      step();
      offer(1'b0, '0);
      step();

      // Random traffic with occasional flushes.
      for (int i = 0; i < 200; i++) begin
         offer(1'($urandom_range(0, 1)), 32'h1000 + 32'(i * 4));
         out_ready = 1'($urandom_range(0, 1));
         flush     = ($urandom_range(0, 11) == 0);
         step();
      end
      flush = 1'b0;
      offer(1'b0, '0);
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) step();
      check("final_count", 64'(count), 64'd0);

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of buffered fetch entries; power of two, 2..16.
REQ-002 SHALL have parameter: WIDTH, 32, width of PC and instruction fields.
REQ-003 SHALL use one clock and a synchronous, active-low reset. Ports are clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 flush  input  1  branch taken; discards all buffered and incoming entries.
REQ-007 in_valid  input  1  the fetch stage presents an entry.
REQ-008 in_pc  input  WIDTH  PC+4 value from the fetch stage.
REQ-009 in_instruction  input  WIDTH  fetched instruction word.
REQ-010 in_ready  output  1  queue can accept an entry this cycle; drives the fetch-stage freeze as ~in_ready.
REQ-011 out_valid  output  1  head entry is valid for the decode stage.
REQ-012 out_pc  output  WIDTH  head entry PC.
REQ-013 out_instruction  output  WIDTH  head entry instruction.
REQ-014 out_ready  input  1  decode stage consumes the head entry this cycle.
REQ-015 count  output  $clog2(DEPTH)+1  number of buffered entries.

Function
REQ-016 SHALL push when in_valid && in_ready && !flush; the entry is written at wr_ptr and wr_ptr is incremented.
REQ-017 SHALL pop when out_valid && out_ready; rd_ptr is incremented.
REQ-018 SHALL wrap wr_ptr and rd_ptr from DEPTH-1 to 0.
REQ-019 SHALL update count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-020 SHALL drive in_ready = (count < DEPTH); when full, in_ready=0 even if a pop occurs in the same cycle.
REQ-021 SHALL drive out_valid = (count != 0) && !flush, and out_pc/out_instruction from the entry at rd_ptr.
REQ-022 SHALL give one cycle of latency, base build: a push at edge N makes the entry visible on out_* after edge N.
REQ-023 SHALL preserve FIFO order; no entry is lost or duplicated across pointer wrap.
REQ-024 SHALL handle flush as follows: at the next edge, count=0, wr_ptr=rd_ptr=0, and any input beat offered that cycle is dropped. flush has priority over push and pop.
REQ-025 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-026 SHALL not modify state on a pop attempt while empty, or on a push attempt while full.

Reset
REQ-027 SHALL, when rst=0 at a clk edge, set count=0, wr_ptr=0 and rd_ptr=0; out_valid=0 and in_ready=1 follow.
REQ-028 SHALL not clear storage contents on reset. out_pc/out_instruction are don't-care while out_valid=0.
REQ-029 SHALL give reset priority over flush, push and pop, including when reset is asserted mid-stream.

Configuration
REQ-030 SHALL use macro IF_ID_QUEUE_BYPASS_EN for bypass.
- Defined: when count==0, in_valid=1, out_ready=1 and flush=0, the input appears on out_* in the same cycle with out_valid=1, and nothing is stored.
- Not defined: no combinational path from in_* to out_*; REQ-022 latency applies.

Structure
REQ-031 SHALL place typedef fetch_entry_t {pc, instruction} and default constant IF_ID_DEPTH in shared package arm_pipe_pkg.
REQ-032 SHALL implement storage in sub-module if_id_queue_mem: DEPTH x fetch_entry_t, one synchronous write port, one asynchronous read port. The pointer/count control stays in if_id_queue.

Verification
REQ-033 Reset: rst=0 for 2 cycles, then 1 -> count=0, out_valid=0, in_ready=1.
REQ-034 Fill: push PCs 0x4, 0x8, 0xC, 0x10 with out_ready=0 -> count=4, in_ready=0; a 5th offer (0x14) is not accepted; then out_ready=1 -> pops in order 0x4, 0x8, 0xC, 0x10.
REQ-035 Wrap: 10 entries streamed with in_valid=out_ready=1 continuously -> all 10 PCs emerge in order and count stays at 1 in steady state (base build).
REQ-036 Flush: 3 entries buffered, flush=1 with in_valid=1 (PC 0x20) -> next cycle count=0 and out_valid=0; 0x20 is never output; the next push, 0x100, is the first output.
REQ-037 Reset mid-operation: count=2, rst=0 together with push and flush -> count=0 after the edge; no entry is output afterwards.
REQ-038 Bypass (IF_ID_QUEUE_BYPASS_EN): queue empty, in_valid=out_ready=1, PC 0x40 -> out_pc=0x40 in the same cycle and count stays 0.
